pendigits_feature_loader: RTL

- Upstream stage of the printed pendigits decision-tree classifiers.
- Accepts pendigits feature samples one 8-bit word per handshake, feature X1 first and X16 last.
- Assembles the 16 words into one registered feature vector and holds it stable for the combinational tree.
- Presents the vector with a valid/ready handshake. Checks framing against an end-of-sample marker and counts accepted and dropped samples.

---
 rtl/pendigits_pkg.sv | 15 +
 rtl/pendigits_wrap_counter.sv | 24 ++
 rtl/pendigits_feature_loader.sv | 111 +++++++++++
 3 files changed

// File: rtl/pendigits_pkg.sv
// Shared constants and state encoding for the pendigits feature loader.
package pendigits_pkg;

    localparam int NUM_FEATURES = 16;
    localparam int FEAT_W       = 8;
    localparam int CNT_W        = 16;
    localparam int IDX_W        = $clog2(NUM_FEATURES);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        HOLD   = 2'd1,
        RESYNC = 2'd2
    } state_t;

endpackage

// File: rtl/pendigits_wrap_counter.sv
// Free-running statistics counter: increments on enable, wraps silently at 2^W.
module pendigits_wrap_counter #(
    parameter int W = pendigits_pkg::CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pendigits_feature_loader.sv
// Assembles 16 framed feature words into one held vector for the decision tree,
// with framing checks and delivered/dropped sample statistics.
module pendigits_feature_loader #(
    parameter int NUM_FEATURES = pendigits_pkg::NUM_FEATURES,
    parameter int FEAT_W       = pendigits_pkg::FEAT_W,
    parameter int CNT_W        = pendigits_pkg::CNT_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [FEAT_W-1:0]              in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_FEATURES*FEAT_W-1:0] out_features,
    output logic                           frame_err,
    output logic [CNT_W-1:0]               sample_count,
    output logic [CNT_W-1:0]               drop_count
);

    import pendigits_pkg::*;

    localparam int                IDX_W    = $clog2(NUM_FEATURES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    state_t                              r_state;
    state_t                              w_state_nxt;
    logic [IDX_W-1:0]                    r_idx;
    logic [NUM_FEATURES-1:0][FEAT_W-1:0] r_slots;
    logic                                r_frame_err;
    logic                                w_fill_fire;
    logic                                w_at_last;
    logic                                w_short;
    logic                                w_long;
    logic                                w_complete;
    logic                                w_store;
    logic                                w_out_fire;

    // Ready/valid depend on state only, so no combinational path crosses the block.
    assign in_ready   = (r_state != HOLD);
    assign out_valid  = (r_state == HOLD);

    assign w_fill_fire = (r_state == FILL) && in_valid;
    assign w_at_last   = (r_idx == LAST_IDX);
    assign w_complete  = w_fill_fire && in_last && w_at_last;
    assign w_short     = w_fill_fire && in_last && !w_at_last;
    assign w_long      = w_fill_fire && !in_last && w_at_last;
    assign w_store     = w_fill_fire && (in_last == w_at_last);
    assign w_out_fire  = (r_state == HOLD) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default at the top of the block keeps every path assigned, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_complete) w_state_nxt = HOLD;
                     else if (w_long) w_state_nxt = RESYNC;
            RESYNC:  if (in_valid && in_last) w_state_nxt = FILL;
            HOLD:    if (out_ready) w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    // Any framing outcome (complete, short or long) restarts the slot index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_short || w_long;
            if (w_fill_fire) begin
                r_idx <= (in_last || w_at_last) ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    // NOTE: the slot array is reset because it drives out_features, which must read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slots <= '0;
        end else if (w_store) begin
            r_slots[r_idx] <= in_data;
        end
    end

    assign out_features = r_slots;
    assign frame_err    = r_frame_err;

    pendigits_wrap_counter #(.W(CNT_W)) u_sample_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_out_fire),
        .o_count (sample_count)
    );

    pendigits_wrap_counter #(.W(CNT_W)) u_drop_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_short || w_long),
        .o_count (drop_count)
    );

endmodule
